btb_update_ctrl: RTL and testbench

Write-port controller for the 512-entry direct-mapped branch target buffer in the dual-issue front end. Accepts up to two update or invalidate requests per cycle from branch resolution, coalesces and buffers them in a small FIFO, and drives the BTB's single write port at one write per cycle. Owns BTB initialisation and flush: after reset or on `flush`, it sweeps all 512 entries invalid, so the BTB array itself carries no reset logic.

---
 rtl/btb_update_ctrl.sv | 158 +++++++++++++++
 tb/tb_btb_update_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// BTB write-port controller: accepts up to two update/invalidate requests per
// cycle, coalesces same-index pairs, buffers them in a small FIFO and drives
// the single BTB write port. Also sweeps all 512 entries invalid after reset
// or flush, so the BTB array needs no reset of its own.

// Per-lane PC decode into BTB index and tag.
module btb_lane_decode (
    input  logic [31:0] pc,
    output logic [8:0]  index,
    output logic [11:0] tag
);
    logic unused_pc_bits;

    assign index          = pc[10:2];
    assign tag            = {pc[30:28], pc[19:11]};
    assign unused_pc_bits = ^{pc[31], pc[27:20], pc[1:0]};
endmodule

module btb_update_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_inv,
    input  logic [1:0][31:0] req_pc,
    input  logic [1:0][31:0] req_target,
    output logic             in_ready,
    output logic             wr_en,
    output logic [8:0]       wr_index,
    output logic             wr_valid,
    output logic [11:0]      wr_tag,
    output logic [31:0]      wr_target,
    output logic             busy
);
    localparam int NUM_LANES = 2;
    localparam int PW        = $clog2(DEPTH);
    localparam int CW        = PW + 1;

    typedef struct packed {
        logic [8:0]  index;
        logic        inv;
        logic [11:0] tag;
        logic [31:0] target;
    } btb_req_t;

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t   state;
    logic [8:0] sweep_idx;
    // Set once index 511 has been written; the following cycle leaves SWEEP
    // so busy stays high while the last sweep write is on the port.
    logic     sweep_wrap;

    btb_req_t          fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    btb_req_t          head;

    logic [NUM_LANES-1:0][8:0]  lane_index;
    logic [NUM_LANES-1:0][11:0] lane_tag;
    btb_req_t [NUM_LANES-1:0]   lane_req;

    logic coalesce, push0, push1, pop;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        btb_lane_decode u_dec (
            .pc    (req_pc[l]),
            .index (lane_index[l]),
            .tag   (lane_tag[l])
        );
        assign lane_req[l] = {lane_index[l], req_inv[l], lane_tag[l], req_target[l]};
    end

    // Room for two pushes is required so both lanes can always be taken together.
    assign in_ready = (state == IDLE) && (count <= CW'(DEPTH - 2)) && !flush;
    assign busy     = (state == SWEEP);

    // Same index on both lanes: the younger lane 1 supersedes lane 0.
    assign coalesce = (&req_valid) && (lane_index[0] == lane_index[1]);
    assign push0    = in_ready && req_valid[0] && !coalesce;
    assign push1    = in_ready && req_valid[1];
    assign pop      = (state == IDLE) && (count != '0) && !flush;
    assign head     = fifo_mem[rd_ptr];

    // FIFO storage: lane 0 lands first, lane 1 in the next slot when both push.
    always_ff @(posedge clk) begin
        if (push0) fifo_mem[wr_ptr] <= lane_req[0];
        if (push1) fifo_mem[wr_ptr + PW'(push0)] <= lane_req[1];
    end

    // FIFO pointers and occupancy; held empty during a sweep and cleared by flush.
    always_ff @(posedge clk) begin
        if (rst || flush || state == SWEEP) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    // Sweep/idle FSM with registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SWEEP;
            sweep_idx  <= '0;
            sweep_wrap <= 1'b0;
            wr_en      <= 1'b0;
            wr_index   <= '0;
            wr_valid   <= 1'b0;
            wr_tag     <= '0;
            wr_target  <= '0;
        end else if (flush) begin
            // Index 0 is written at this edge, so the sweep continues from 1.
            state      <= SWEEP;
            sweep_idx  <= 9'd1;
            sweep_wrap <= 1'b0;
            wr_en      <= 1'b1;
            wr_index   <= '0;
            wr_valid   <= 1'b0;
            wr_tag     <= '0;
            wr_target  <= '0;
        end else begin
            case (state)
                SWEEP: begin
                    if (sweep_wrap) begin
                        state      <= IDLE;
                        sweep_wrap <= 1'b0;
                        wr_en      <= 1'b0;
                    end else begin
                        wr_en     <= 1'b1;
                        wr_index  <= sweep_idx;
                        wr_valid  <= 1'b0;
                        wr_tag    <= '0;
                        wr_target <= '0;
                        sweep_idx <= sweep_idx + 9'd1;
                        if (sweep_idx == 9'd511) sweep_wrap <= 1'b1;
                    end
                end
                IDLE: begin
                    if (pop) begin
                        wr_en     <= 1'b1;
                        wr_index  <= head.index;
                        wr_valid  <= !head.inv;
                        wr_tag    <= head.inv ? '0 : head.tag;
                        wr_target <= head.inv ? '0 : head.target;
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: reset sweep, single/dual/coalesced
// requests, back-pressure under sustained dual issue, and flush behaviour.
module tb_btb_update_ctrl;
    logic             clk = 1'b0;
    logic             rst, flush;
    logic [1:0]       req_valid, req_inv;
    logic [1:0][31:0] req_pc, req_target;
    logic             in_ready, wr_en, wr_valid, busy;
    logic [8:0]       wr_index;
    logic [11:0]      wr_tag;
    logic [31:0]      wr_target;

    int n_tests = 0;
    int n_fail  = 0;

    btb_update_ctrl #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_inv    (req_inv),
        .req_pc     (req_pc),
        .req_target (req_target),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .wr_valid   (wr_valid),
        .wr_tag     (wr_tag),
        .wr_target  (wr_target),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_valid  = '0;
        req_inv    = '0;
        req_pc     = '0;
        req_target = '0;
    endtask

    // Current cycle shows sweep index 'first'; follow it to 511, then expect idle.
    task automatic check_sweep(input string tag, input int first);
        int bad = 0;
        for (int i = first; i < 512; i++) begin
            if (i > first) tick();
            if (!(wr_en === 1'b1 && wr_index === 9'(i) && wr_valid === 1'b0 &&
                  wr_tag === 12'h0 && wr_target === 32'h0 && busy === 1'b1 && in_ready === 1'b0))
                bad++;
        end
        check({tag, "_seq"}, bad, 0);
        tick();
        check({tag, "_busy_done"}, busy, 1'b0);
        check({tag, "_ready_done"}, in_ready, 1'b1);
        check({tag, "_wr_en_done"}, wr_en, 1'b0);
    endtask

    initial begin
        logic [8:0] exp_q[$];
        logic [8:0] e;
        int order_err, ready_err, stall_seen, nwr, nacc, mcount, seq, extra, bad;

        rst = 1'b1;
        flush = 1'b0;
        idle_in();

        // ---- reset ----
        tick();
        tick();
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_index", wr_index, 9'h0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_tag", wr_tag, 12'h0);
        check("rst_wr_target", wr_target, 32'h0);
        check("rst_busy", busy, 1'b1);
        check("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        tick();
        check_sweep("reset_sweep", 0);

        // ---- single install: pc 0x12345678 -> index 0x19E,
        //      tag {pc[30:28]=3'b001, pc[19:11]=9'h08A} = 12'h28A ----
        req_valid = 2'b01;
        req_inv   = 2'b00;
        req_pc[0] = 32'h1234_5678;
        req_target[0] = 32'h0000_4000;
        tick();
        idle_in();
        check("single_c1_wr_en", wr_en, 1'b0);
        tick();
        check("single_wr_en", wr_en, 1'b1);
        check("single_index", wr_index, 9'h19E);
        check("single_tag", wr_tag, 12'h28A);
        check("single_target", wr_target, 32'h4000);
        check("single_valid", wr_valid, 1'b1);
        tick();
        check("single_c3_wr_en", wr_en, 1'b0);

        // ---- two lanes, distinct indices ----
        req_valid = 2'b11;
        req_pc[0] = 32'h100;  req_target[0] = 32'hAAAA_0000;
        req_pc[1] = 32'h204;  req_target[1] = 32'hBBBB_0000;
        tick();
        idle_in();
        tick();
        check("dual_l0_index", wr_index, 9'h040);
        check("dual_l0_target", wr_target, 32'hAAAA_0000);
        tick();
        check("dual_l1_wr_en", wr_en, 1'b1);
        check("dual_l1_index", wr_index, 9'h081);
        check("dual_l1_target", wr_target, 32'hBBBB_0000);
        tick();
        check("dual_c4_wr_en", wr_en, 1'b0);

        // ---- coalesce: lane 0 install, lane 1 invalidate, same pc ----
        req_valid = 2'b11;
        req_inv   = 2'b10;
        req_pc[0] = 32'h100;  req_target[0] = 32'hDEAD_BEEF;
        req_pc[1] = 32'h100;  req_target[1] = 32'h1111_2222;
        tick();
        idle_in();
        tick();
        check("coal_wr_en", wr_en, 1'b1);
        check("coal_index", wr_index, 9'h040);
        check("coal_valid", wr_valid, 1'b0);
        check("coal_tag", wr_tag, 12'h0);
        check("coal_target", wr_target, 32'h0);
        tick();
        check("coal_single_write", wr_en, 1'b0);

        // ---- sustained dual issue against DEPTH=4 ----
        order_err = 0; ready_err = 0; stall_seen = 0; nwr = 0; nacc = 0;
        mcount = 0; seq = 32'h20;
        for (int c = 0; c < 28; c++) begin
            if (wr_en === 1'b1) begin
                nwr++;
                if (exp_q.size() == 0) order_err++;
                else begin
                    e = exp_q.pop_front();
                    if (wr_index !== e || wr_valid !== 1'b1) order_err++;
                end
            end
            if (c < 20) begin
                if (in_ready !== (mcount <= 2)) ready_err++;
                if (mcount == 3 && in_ready === 1'b0) stall_seen = 1;
                req_valid = 2'b11;
                req_inv   = 2'b00;
                req_pc[0] = 32'(seq) << 2;
                req_pc[1] = 32'(seq + 1) << 2;
                req_target[0] = 32'(seq);
                req_target[1] = 32'(seq + 1);
                if (mcount <= 2) begin
                    exp_q.push_back(9'(seq));
                    exp_q.push_back(9'(seq + 1));
                    nacc += 2;
                    seq  += 2;
                    mcount = mcount + 2 - ((mcount > 0) ? 1 : 0);
                end else begin
                    mcount = mcount - 1;
                end
            end else begin
                idle_in();
            end
            tick();
        end
        check("stress_order", order_err, 0);
        check("stress_ready", ready_err, 0);
        check("stress_stall_seen", stall_seen, 1);
        check("stress_count", nwr, nacc);
        check("stress_drained", exp_q.size(), 0);

        // ---- flush with three entries queued ----
        req_valid = 2'b11;
        req_inv   = 2'b00;
        req_pc[0] = 32'h300;  req_target[0] = 32'h11;
        req_pc[1] = 32'h304;  req_target[1] = 32'h22;
        tick();
        check("fl_c1_ready", in_ready, 1'b1);
        req_pc[0] = 32'h308;  req_target[0] = 32'h33;
        req_pc[1] = 32'h30C;  req_target[1] = 32'h44;
        tick();
        check("fl_prev_write_en", wr_en, 1'b1);
        check("fl_prev_write_idx", wr_index, 9'h0C0);
        flush = 1'b1;
        req_pc[0] = 32'h310;
        req_pc[1] = 32'h314;
        #1;
        check("fl_ready_low", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        idle_in();
        check("fl_idx0_en", wr_en, 1'b1);
        check("fl_idx0", wr_index, 9'h0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (i > 0) tick();
            if (!(wr_en === 1'b1 && wr_index === 9'(i) && wr_valid === 1'b0 && busy === 1'b1))
                bad++;
        end
        check("fl_partial_sweep", bad, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl2_idx0_en", wr_en, 1'b1);
        check("fl2_idx0", wr_index, 9'h0);
        check_sweep("fl2_sweep", 0);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wr_en !== 1'b0) extra++;
        end
        check("fl_no_stale_write", extra, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
